// File: rtl/div_pkg.sv
// Shared widths, FSM state encoding and counter sizing for the sequential divider.
package div_pkg;

  localparam int DIVIDEND_W_DEF = 16;
  localparam int DIVISOR_W_DEF  = 8;

  // Step counter must be able to hold DIVIDEND_W
  localparam int CNT_W = $clog2(DIVIDEND_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module div_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] rem_o,
  output logic                 q_bit_o
);

  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W-1:0] diff;

  // The restored remainder stays below the divisor, so after a subtraction the
  // true difference always fits in DIVISOR_W bits.
  always_comb begin
    shifted = {rem_i, bit_i};
    q_bit_o = (shifted >= {1'b0, divisor_i});
    diff    = shifted[DIVISOR_W-1:0] - divisor_i;
    rem_o   = q_bit_o ? diff : shifted[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional DIV_ZERO_DETECT_EN: zero divisor short-circuits straight to DONE and raises div_by_zero.
module seq_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CW = $clog2(DIVIDEND_W + 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB
  logic [DIVIDEND_W-1:0]   dq_q, dq_d;
  logic [DIVISOR_W-1:0]    dsr_q, dsr_d;
  logic [DIVISOR_W-1:0]    rem_q, rem_d;
  logic [DIVIDEND_W-1:0]   quo_q, quo_d;
  logic [DIVISOR_W-1:0]    rmd_q, rmd_d;

  logic [DIVISOR_W-1:0]    rem_nxt;
  logic                    q_bit;
  logic                    last_step;
  logic                    accept;
  logic                    zero_skip;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dq_q[DIVIDEND_W-1]),
    .divisor_i (dsr_q),
    .rem_o     (rem_nxt),
    .q_bit_o   (q_bit)
  );

  assign last_step = (cnt_q == CW'(DIVIDEND_W - 1));
  assign accept    = (state_q == IDLE) && start;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_skip = (divisor == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = zero_skip ? DONE : RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    cnt_d = cnt_q;
    dq_d  = dq_q;
    dsr_d = dsr_q;
    rem_d = rem_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    if (accept) begin
      cnt_d = '0;
      dq_d  = dividend;
      dsr_d = divisor;
      rem_d = '0;
      if (zero_skip) begin
        quo_d = '1;
        rmd_d = dividend[DIVISOR_W-1:0];
      end
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + CW'(1);
      dq_d  = {dq_q[DIVIDEND_W-2:0], q_bit};
      rem_d = rem_nxt;
      if (last_step) begin
        quo_d = {dq_q[DIVIDEND_W-2:0], q_bit};
        rmd_d = rem_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dq_q  <= '0;
      dsr_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      rmd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dq_q  <= dq_d;
      dsr_q <= dsr_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rmd_q;

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q, dbz_d;

  // Set by the skip path, cleared by any division that completes through RUN
  always_comb begin
    dbz_d = dbz_q;
    if (accept && zero_skip)             dbz_d = 1'b1;
    else if (state_q == RUN && last_step) dbz_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbz_q <= 1'b0;
    else        dbz_q <= dbz_d;
  end

  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
